// File: rtl/dispatch_unit_pkg.sv
// Shared types and width constants for the dispatch stage.
// Optional CSEL decode is enabled with DISPATCH_CSEL_EN.
package data_structures;

  localparam int GPR_SIZE       = 64;
  localparam int INSNBITS_SIZE  = 32;
  localparam int GPR_IDX_SIZE   = 5;
  localparam int IMMEDIATE_SIZE = 64;

  localparam logic [GPR_IDX_SIZE-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_LS   = 2'd2
  } fu_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_ORR   = 4'd4,
    OP_EOR   = 4'd5,
    OP_MOVZ  = 4'd6,
    OP_LDUR  = 4'd7,
    OP_STUR  = 4'd8,
    OP_BCOND = 4'd9,
    OP_CSEL  = 4'd10
  } fu_op_t;

  typedef logic [3:0] cond_t;

  typedef struct packed {
    logic                      valid;
    logic                      set_nzcv;
    logic                      uses_nzcv;
    logic                      use_imm;
    logic [IMMEDIATE_SIZE-1:0] imm;
    logic [GPR_IDX_SIZE-1:0]   src1;
    logic                      src1_used;
    logic [GPR_IDX_SIZE-1:0]   src2;
    logic                      src2_used;
    logic [GPR_IDX_SIZE-1:0]   dst;
    fu_t                       fu_id;
    fu_op_t                    fu_op;
    cond_t                     cond;
  } uop_t;

endpackage

// File: rtl/dispatch_unit_decoder.sv
// Combinational AArch64 decode of one word into a micro-op.
// CSEL is recognised only when DISPATCH_CSEL_EN is defined.
module insn_decoder
  import data_structures::*;
(
  input  logic [INSNBITS_SIZE-1:0] insn_i,
  output uop_t                     uop_o
);

  logic [7:0]              op8;
  logic [GPR_IDX_SIZE-1:0] rd;
  logic [GPR_IDX_SIZE-1:0] rn;
  logic [GPR_IDX_SIZE-1:0] rm;
  logic                    is_addi;
  logic                    is_alur;
  logic                    is_movz;
  logic                    is_ldur;
  logic                    is_stur;
  logic                    is_bcond;
  logic                    is_csel;

  assign op8 = insn_i[31:24];
  assign rd  = insn_i[4:0];
  assign rn  = insn_i[9:5];
  assign rm  = insn_i[20:16];

  assign is_addi = (op8 inside {8'h91, 8'hB1, 8'hD1, 8'hF1})
                 && !insn_i[22];
  assign is_alur = (op8 inside {8'h8B, 8'hAB, 8'hCB, 8'hEB,
                                8'h8A, 8'hAA, 8'hCA, 8'hEA})
                 && (insn_i[23:21] == 3'b000)
                 && (insn_i[15:10] == 6'd0);
  assign is_movz = insn_i[31:23] == 9'b110100101;
  assign is_ldur = (insn_i[31:21] == 11'b11111000010)
                 && (insn_i[11:10] == 2'b00);
  assign is_stur = insn_i[31:21] == 11'b11111000000;
  assign is_bcond = (op8 == 8'h54) && !insn_i[4];

`ifdef DISPATCH_CSEL_EN
  assign is_csel = (insn_i[31:21] == 11'b10011010100)
                 && (insn_i[11:10] == 2'b00);
`else
  assign is_csel = 1'b0;
`endif

  always_comb begin
    uop_o = '0;
    unique case (1'b1)
      is_addi: begin
        uop_o.valid     = 1'b1;
        uop_o.fu_id     = FU_ALU;
        uop_o.fu_op     = insn_i[30] ? OP_SUB : OP_ADD;
        uop_o.set_nzcv  = insn_i[29];
        uop_o.use_imm   = 1'b1;
        uop_o.imm       = {52'd0, insn_i[21:10]};
        uop_o.src1      = rn;
        uop_o.src1_used = rn != XZR;
        uop_o.dst       = rd;
      end
      is_alur: begin
        uop_o.valid     = 1'b1;
        uop_o.fu_id     = FU_ALU;
        uop_o.src1      = rn;
        uop_o.src1_used = rn != XZR;
        uop_o.src2      = rm;
        uop_o.src2_used = rm != XZR;
        uop_o.dst       = rd;
        // bit 24 splits add/sub from the logical group
        if (insn_i[24]) begin
          uop_o.fu_op    = insn_i[30] ? OP_SUB : OP_ADD;
          uop_o.set_nzcv = insn_i[29];
        end else begin
          unique case (insn_i[30:29])
            2'b00:   uop_o.fu_op = OP_AND;
            2'b01:   uop_o.fu_op = OP_ORR;
            2'b10:   uop_o.fu_op = OP_EOR;
            default: uop_o.fu_op = OP_AND;
          endcase
          uop_o.set_nzcv = &insn_i[30:29];
        end
      end
      is_movz: begin
        uop_o.valid   = 1'b1;
        uop_o.fu_id   = FU_ALU;
        uop_o.fu_op   = OP_MOVZ;
        uop_o.use_imm = 1'b1;
        uop_o.imm     = {48'd0, insn_i[20:5]}
                     << {insn_i[22:21], 4'd0};
        uop_o.dst     = rd;
      end
      is_ldur: begin
        uop_o.valid     = 1'b1;
        uop_o.fu_id     = FU_LS;
        uop_o.fu_op     = OP_LDUR;
        uop_o.use_imm   = 1'b1;
        uop_o.imm       = {{55{insn_i[20]}}, insn_i[20:12]};
        uop_o.src1      = rn;
        uop_o.src1_used = rn != XZR;
        uop_o.dst       = rd;
      end
      is_stur: begin
        uop_o.valid     = 1'b1;
        uop_o.fu_id     = FU_LS;
        uop_o.fu_op     = OP_STUR;
        uop_o.use_imm   = 1'b1;
        uop_o.imm       = {{55{insn_i[20]}}, insn_i[20:12]};
        uop_o.src1      = rn;
        uop_o.src1_used = rn != XZR;
        uop_o.src2      = rd;
        uop_o.src2_used = rd != XZR;
        uop_o.dst       = XZR;
      end
      is_bcond: begin
        uop_o.valid     = 1'b1;
        uop_o.fu_id     = FU_ALU;
        uop_o.fu_op     = OP_BCOND;
        uop_o.use_imm   = 1'b1;
        uop_o.imm       = {{43{insn_i[23]}}, insn_i[23:5], 2'b00};
        uop_o.uses_nzcv = 1'b1;
        uop_o.cond      = insn_i[3:0];
        uop_o.dst       = XZR;
      end
      is_csel: begin
        uop_o.valid     = 1'b1;
        uop_o.fu_id     = FU_ALU;
        uop_o.fu_op     = OP_CSEL;
        uop_o.uses_nzcv = 1'b1;
        uop_o.cond      = insn_i[15:12];
        uop_o.src1      = rn;
        uop_o.src1_used = rn != XZR;
        uop_o.src2      = rm;
        uop_o.src2_used = rm != XZR;
        uop_o.dst       = rd;
      end
      default: uop_o = '0;
    endcase
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: decode plus one output register with reset and flush.
// Build with DISPATCH_CSEL_EN to also dispatch CSEL.
module dispatch_unit
  import data_structures::*;
(
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_rob_mispredict,
  input  logic                      in_fetch_done,
  input  logic [INSNBITS_SIZE-1:0]  in_fetch_insnbits,
  input  logic [GPR_SIZE-1:0]       in_fetch_pc,
  output logic                      out_reg_done,
  output logic                      out_reg_set_nzcv,
  output logic                      out_reg_uses_nzcv,
  output logic                      out_reg_use_imm,
  output logic [IMMEDIATE_SIZE-1:0] out_reg_imm,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_src1,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_src2,
  output logic                      out_reg_src1_used,
  output logic                      out_reg_src2_used,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_dst,
  output fu_t                       out_reg_fu_id,
  output fu_op_t                    out_reg_fu_op,
  output cond_t                     out_reg_cond_codes,
  output logic [GPR_SIZE-1:0]       out_reg_pc
);

  uop_t                dec;
  uop_t                uop_d;
  uop_t                uop_q;
  logic [GPR_SIZE-1:0] pc_d;
  logic [GPR_SIZE-1:0] pc_q;

  insn_decoder u_dec (
    .insn_i (in_fetch_insnbits),
    .uop_o  (dec)
  );

  // Anything not dispatched this cycle leaves an all-zero record
  always_comb begin
    uop_d = '0;
    pc_d  = '0;
    if (in_fetch_done && !in_rob_mispredict && dec.valid) begin
      uop_d = dec;
      pc_d  = in_fetch_pc;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      uop_q <= '0;
      pc_q  <= '0;
    end else begin
      uop_q <= uop_d;
      pc_q  <= pc_d;
    end
  end

  assign out_reg_done       = uop_q.valid;
  assign out_reg_set_nzcv   = uop_q.set_nzcv;
  assign out_reg_uses_nzcv  = uop_q.uses_nzcv;
  assign out_reg_use_imm    = uop_q.use_imm;
  assign out_reg_imm        = uop_q.imm;
  assign out_reg_src1       = uop_q.src1;
  assign out_reg_src2       = uop_q.src2;
  assign out_reg_src1_used  = uop_q.src1_used;
  assign out_reg_src2_used  = uop_q.src2_used;
  assign out_reg_dst        = uop_q.dst;
  assign out_reg_fu_id      = uop_q.fu_id;
  assign out_reg_fu_op      = uop_q.fu_op;
  assign out_reg_cond_codes = uop_q.cond;
  assign out_reg_pc         = pc_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed-vector bench for dispatch_unit.
// Expectations are hand-decoded from the AArch64 encodings.
module tb_dispatch_unit;
  import data_structures::*;

  logic        clk;
  logic        rst;
  logic        mispredict;
  logic        fdone;
  logic [31:0] insn;
  logic [63:0] pc;

  logic        done;
  logic        set_nzcv;
  logic        uses_nzcv;
  logic        use_imm;
  logic [63:0] imm;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        src1_used;
  logic        src2_used;
  logic [4:0]  dst;
  fu_t         fu_id;
  fu_op_t      fu_op;
  cond_t       cond;
  logic [63:0] opc;

  int checks = 0;
  int passed = 0;

  dispatch_unit dut (
    .in_clk             (clk),
    .in_rst             (rst),
    .in_rob_mispredict  (mispredict),
    .in_fetch_done      (fdone),
    .in_fetch_insnbits  (insn),
    .in_fetch_pc        (pc),
    .out_reg_done       (done),
    .out_reg_set_nzcv   (set_nzcv),
    .out_reg_uses_nzcv  (uses_nzcv),
    .out_reg_use_imm    (use_imm),
    .out_reg_imm        (imm),
    .out_reg_src1       (src1),
    .out_reg_src2       (src2),
    .out_reg_src1_used  (src1_used),
    .out_reg_src2_used  (src2_used),
    .out_reg_dst        (dst),
    .out_reg_fu_id      (fu_id),
    .out_reg_fu_op      (fu_op),
    .out_reg_cond_codes (cond),
    .out_reg_pc         (opc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [63:0] p);
    fdone = 1'b1;
    insn  = w;
    pc    = p;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mispredict = 1'b0;
    drive(32'h91001421, 64'h40);
    step();
    checks++; if (done !== 1'b0) $display("FAIL rst_done got %0d exp 0", done); else passed++;
    checks++; if (fu_op !== OP_NOP) $display("FAIL rst_op got %0d exp 0", fu_op); else passed++;
    checks++; if (imm !== 64'd0) $display("FAIL rst_imm got %h exp 0", imm); else passed++;
    checks++; if (fu_id !== FU_NONE) $display("FAIL rst_fu got %0d exp 0", fu_id); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_add_imm();
    drive(32'h91001421, 64'h200);
    step();
    checks++; if (done !== 1'b1) $display("FAIL add_done got %0d exp 1", done); else passed++;
    checks++; if (src1 !== 5'd1 || src1_used !== 1'b1) $display("FAIL add_src1 got %0d/%0d exp 1/1", src1, src1_used); else passed++;
    checks++; if (use_imm !== 1'b1 || imm !== 64'd5) $display("FAIL add_imm got %0d/%h exp 1/5", use_imm, imm); else passed++;
    checks++; if (dst !== 5'd1) $display("FAIL add_dst got %0d exp 1", dst); else passed++;
    checks++; if (fu_id !== FU_ALU || fu_op !== OP_ADD) $display("FAIL add_fu got %0d/%0d exp 1/1", fu_id, fu_op); else passed++;
    checks++; if (set_nzcv !== 1'b0 || src2_used !== 1'b0) $display("FAIL add_flags got %0d/%0d exp 0/0", set_nzcv, src2_used); else passed++;
    checks++; if (opc !== 64'h200) $display("FAIL add_pc got %h exp 200", opc); else passed++;
  endtask

  task automatic test_cmp();
    drive(32'hF100283F, 64'h204);
    step();
    checks++; if (fu_op !== OP_SUB || set_nzcv !== 1'b1) $display("FAIL cmp_op got %0d/%0d exp 2/1", fu_op, set_nzcv); else passed++;
    checks++; if (dst !== 5'd31 || imm !== 64'd10) $display("FAIL cmp_dst got %0d/%h exp 31/a", dst, imm); else passed++;
  endtask

  task automatic test_stur();
    drive(32'hF81F8022, 64'h208);
    step();
    checks++; if (fu_id !== FU_LS || fu_op !== OP_STUR) $display("FAIL stur_fu got %0d/%0d exp 2/8", fu_id, fu_op); else passed++;
    checks++; if (src1 !== 5'd1 || src2 !== 5'd2 || src2_used !== 1'b1) $display("FAIL stur_src got %0d/%0d/%0d exp 1/2/1", src1, src2, src2_used); else passed++;
    checks++; if (imm !== 64'hFFFFFFFFFFFFFFF8) $display("FAIL stur_imm got %h exp fffffffffffffff8", imm); else passed++;
    checks++; if (dst !== 5'd31) $display("FAIL stur_dst got %0d exp 31", dst); else passed++;
  endtask

  task automatic test_ldur();
    drive(32'hF8410044, 64'h20C);
    step();
    checks++; if (fu_id !== FU_LS || fu_op !== OP_LDUR) $display("FAIL ldur_fu got %0d/%0d exp 2/7", fu_id, fu_op); else passed++;
    checks++; if (imm !== 64'd16 || dst !== 5'd4 || src1 !== 5'd2) $display("FAIL ldur_fields got %h/%0d/%0d exp 10/4/2", imm, dst, src1); else passed++;
  endtask

  task automatic test_bcond();
    drive(32'h54FFFFE1, 64'h100);
    step();
    checks++; if (fu_op !== OP_BCOND || cond !== 4'd1) $display("FAIL bc_op got %0d/%0d exp 9/1", fu_op, cond); else passed++;
    checks++; if (uses_nzcv !== 1'b1 || dst !== 5'd31) $display("FAIL bc_flags got %0d/%0d exp 1/31", uses_nzcv, dst); else passed++;
    checks++; if (imm !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL bc_imm got %h exp fffffffffffffffc", imm); else passed++;
    checks++; if (opc !== 64'h100) $display("FAIL bc_pc got %h exp 100", opc); else passed++;
  endtask

  task automatic test_movz();
    drive(32'hD2A24683, 64'h210);
    step();
    checks++; if (fu_op !== OP_MOVZ || imm !== 64'h12340000) $display("FAIL movz got %0d/%h exp 6/12340000", fu_op, imm); else passed++;
    checks++; if (src1_used !== 1'b0 || dst !== 5'd3) $display("FAIL movz_regs got %0d/%0d exp 0/3", src1_used, dst); else passed++;
  endtask

  task automatic test_alu_reg();
    drive(32'h8B0700C5, 64'h214);
    step();
    checks++; if (fu_op !== OP_ADD || src1 !== 5'd6 || src2 !== 5'd7 || dst !== 5'd5) $display("FAIL addr got %0d/%0d/%0d/%0d exp 1/6/7/5", fu_op, src1, src2, dst); else passed++;
    checks++; if (use_imm !== 1'b0 || src2_used !== 1'b1) $display("FAIL addr_use got %0d/%0d exp 0/1", use_imm, src2_used); else passed++;
    drive(32'hEA1F0020, 64'h218);
    step();
    checks++; if (fu_op !== OP_AND || set_nzcv !== 1'b1) $display("FAIL ands got %0d/%0d exp 3/1", fu_op, set_nzcv); else passed++;
    checks++; if (src2 !== 5'd31 || src2_used !== 1'b0) $display("FAIL ands_xzr got %0d/%0d exp 31/0", src2, src2_used); else passed++;
  endtask

  task automatic test_unsupported();
    drive(32'h00000000, 64'h300);
    step();
    checks++; if (done !== 1'b0 || fu_op !== OP_NOP || opc !== 64'd0) $display("FAIL zero_word got %0d/%0d/%h exp 0/0/0", done, fu_op, opc); else passed++;
    drive(32'h91401421, 64'h304);
    step();
    checks++; if (done !== 1'b0) $display("FAIL addi_sh12 got %0d exp 0", done); else passed++;
    drive(32'h9A830041, 64'h308);
    step();
`ifdef DISPATCH_CSEL_EN
    checks++; if (done !== 1'b1 || fu_op !== OP_CSEL || src2 !== 5'd3) $display("FAIL csel got %0d/%0d/%0d exp 1/10/3", done, fu_op, src2); else passed++;
`else
    checks++; if (done !== 1'b0 || fu_op !== OP_NOP) $display("FAIL csel_off got %0d/%0d exp 0/0", done, fu_op); else passed++;
`endif
  endtask

  task automatic test_flush();
    drive(32'h91001421, 64'h400);
    mispredict = 1'b1;
    step();
    checks++; if (done !== 1'b0) $display("FAIL flush got %0d exp 0", done); else passed++;
    mispredict = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(32'h91001421, 64'h500);
    step();
    checks++; if (done !== 1'b1 || dst !== 5'd1) $display("FAIL b2b_0 got %0d/%0d exp 1/1", done, dst); else passed++;
    drive(32'hF100283F, 64'h504);
    step();
    checks++; if (done !== 1'b1 || dst !== 5'd31 || opc !== 64'h504) $display("FAIL b2b_1 got %0d/%0d/%h exp 1/31/504", done, dst, opc); else passed++;
    fdone = 1'b0;
    step();
    checks++; if (done !== 1'b0) $display("FAIL b2b_idle got %0d exp 0", done); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    mispredict = 1'b0;
    fdone = 1'b0;
    insn = '0;
    pc = '0;
    step();
    test_reset();
    test_add_imm();
    test_cmp();
    test_stur();
    test_ldur();
    test_bcond();
    test_movz();
    test_alu_reg();
    test_unsupported();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
